// File: rtl/mul_div_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they behave as MULTU/DIVU.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] r_data1,
    input  logic [WIDTH-1:0] r_data2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_ddiff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    assign w_signed = SIGNED_EN & ~op[0];
    assign w_a_mag  = (w_signed & r_data1[WIDTH-1]) ? -r_data1 : r_data1;
    assign w_b_mag  = (w_signed & r_data2[WIDTH-1]) ? -r_data2 : r_data2;

    // Multiply: r_acc = {partial product, remaining multiplier bits}
    assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Divide: r_acc = {remainder, dividend bits shifting into quotient}
    assign w_dsh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ddiff = w_dsh - {1'b0, r_b};

    assign w_prod = r_neg_q ? -r_acc : r_acc;

    always_comb begin
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            // Remainder sign correction also restores the raw dividend on divide-by-zero.
            w_hi_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_lo_fix = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            r_state  <= S_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_is_div <= op[1];
                            r_neg_q  <= w_signed & (r_data1[WIDTH-1] ^ r_data2[WIDTH-1]);
                            r_neg_r  <= w_signed & r_data1[WIDTH-1];
                            r_div0   <= (r_data2 == '0);
                            r_b      <= op[1] ? w_b_mag : w_a_mag;
                            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
                        end
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_is_div) begin
                            if (!w_ddiff[WIDTH])
                                r_acc <= {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                            else
                                r_acc <= {w_dsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                        end else begin
                            r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO, a monitor checks on done.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] r_data1 = '0;
    logic [31:0] r_data2 = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .r_data1(r_data1), .r_data2(r_data2), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   pushed = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi_out, e.hi);
                chk({e.name, "_lo"}, lo_out, e.lo);
            end
        end
    end

    // Launch one op, optionally poke start/hi_we mid-flight, and measure busy length.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm,
                          input bit inject);
        exp_t e;
        int   n;
        e.hi = ehi; e.lo = elo; e.name = nm;
        @(negedge clock);
        start = 1'b1; op = o; r_data1 = a; r_data2 = b;
        sb.push_back(e);
        pushed++;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            if (inject && n == 5) begin
                start = 1'b1; op = OP_DIVU; r_data1 = 32'd9; r_data2 = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({nm, "_busy_cycles"}, 32'(n), 32'd33);
    endtask

    task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clock);
        hi_we = 1'b1; wdata = hv;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
        @(negedge clock);
        lo_we = 1'b0;
    endtask

    initial begin
        int dc;
        repeat (2) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        reset = 1'b0;

        // MTHI/MTLO one-cycle latency, both at once
        @(negedge clock);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both_hi", hi_out, 32'hA5A5_0001);
        chk("mt_both_lo", lo_out, 32'hA5A5_0001);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1);
`ifdef MULDIV_SIGNED_EN
        run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg7x3", 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2", 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 1'b0);
`else
        run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'h0000_0002, 32'hFFFF_FFEB, "mult_neg7x3", 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, "div_neg7by2", 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, "div_ovf", 1'b0);
`endif
        run_op(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0", 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0", 1'b0);
        run_op(OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, "multu_shift", 1'b0);
        run_op(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, "divu_1000by7", 1'b0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq", 1'b0);

        // Flush mid-divide: HI/LO keep MTHI/MTLO values, no done
        mt_write(32'h1234, 32'h5678);
        chk("mt_hi", hi_out, 32'h1234);
        chk("mt_lo", lo_out, 32'h5678);
        dc = done_cnt;
        @(negedge clock);
        start = 1'b1; op = OP_DIVU; r_data1 = 32'd1000; r_data2 = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy_drop", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clock);
        chk("flush_hi_kept", hi_out, 32'h1234);
        chk("flush_lo_kept", lo_out, 32'h5678);
        chk("flush_no_done", 32'(done_cnt - dc), 32'd0);

        // flush together with start in IDLE: start dropped
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = OP_MULTU; r_data1 = 32'd5; r_data2 = 32'd5;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_dropped", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-multiply
        @(negedge clock);
        start = 1'b1; op = OP_MULTU; r_data1 = 32'd77; r_data2 = 32'd99;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'b0, busy}, 32'd0);
        chk("async_reset_done", {31'b0, done}, 32'd0);
        chk("async_reset_hi", hi_out, 32'd0);
        chk("async_reset_lo", lo_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("post_reset_idle", {31'b0, busy}, 32'd0);

        chk("done_count", 32'(done_cnt), 32'(pushed));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
